ctr_sched: RTL and testbench

CTR_SCHED -- requirements
Module: ctr_sched

---
 rtl/ctr_sched_pkg.sv | 17 +
 rtl/rr_pick.sv | 31 +++
 rtl/ctr_sched.sv | 102 ++++++++++
 tb/tb_ctr_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ctr_sched_pkg.sv
// Shared types and defaults for the round-robin burst counter scheduler.
package ctr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr.
module rr_pick
    import ctr_sched_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic found;
    int   j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                idx   = IW'(j);
                found = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/ctr_sched.sv
// Shared burst counter handed out round-robin to NREQ requesters.
module ctr_sched
    import ctr_sched_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int CW   = CW_DEF,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [CW-1:0]      cnt,
    output logic               done,
    output logic [IW-1:0]      done_id,
    output logic               abort
);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] own;
    logic [IW-1:0] pick;
    logic [IW-1:0] nxt;
    logic          pick_v;
    logic [CW-1:0] lm1;
    logic [CW-1:0] win_len;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick),
        .valid (pick_v)
    );

    // lm1 = L-1; a zero length wraps to all-ones, i.e. 2^CW cycles
    always_comb begin
        win_len = len[int'(pick)*CW +: CW];
        nxt     = (int'(own) == NREQ - 1) ? '0 : own + IW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            abort   <= 1'b0;
            ptr     <= '0;
            own     <= '0;
            lm1     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done  <= 1'b0;
                    abort <= 1'b0;
                    if (pick_v) begin
                        state <= RUN;
                        grant <= NREQ'(1) << pick;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        own   <= pick;
                        lm1   <= win_len - CW'(1);
                    end else begin
                        grant <= '0;
                    end
                end
                RUN: begin
                    if (!req[own] || cnt == lm1) begin
                        state   <= DONE;
                        grant   <= '0;
                        done    <= 1'b1;
                        abort   <= !req[own];
                        done_id <= own;
                        ptr     <= nxt;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    abort <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    abort <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_sched.sv
// Vector table plus done-event scoreboard for ctr_sched.
module tb_ctr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] len;
    logic [3:0]  grant;
    logic        busy;
    logic [2:0]  cnt;
    logic        done;
    logic [1:0]  done_id;
    logic        abort;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   id;
        logic abort;
        int   cnt;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] len;
        int          id;
        int          L;
        int          drop_at;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];
    vec_t tail_v;

    ctr_sched dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
        .grant   (grant),
        .busy    (busy),
        .cnt     (cnt),
        .done    (done),
        .done_id (done_id),
        .abort   (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] mklen(input int a, input int b,
                                         input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // every done pulse must match the oldest expected burst end
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got done=1 expected done=0");
            end else begin
                mon_e = sb.pop_front();
                chk("done_id", int'(done_id), mon_e.id);
                chk("done_abort", int'(abort), int'(mon_e.abort));
                chk("done_cnt", int'(cnt), mon_e.cnt);
            end
        end else begin
            chk("abort_low", int'(abort), 0);
        end
    end

    task automatic run_vec(input vec_t v);
        int         n;
        int         fin;
        logic [3:0] oh;
        exp_t       e;
        n   = (v.drop_at >= 0) ? v.drop_at + 1 : v.L;
        fin = n - 1;
        oh  = 4'(1 << v.id);
        e.id    = v.id;
        e.abort = (v.drop_at >= 0);
        e.cnt   = fin;
        sb.push_back(e);
        req = v.req;
        len = v.len;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("run_grant", int'(grant), int'(oh));
            chk("run_cnt", int'(cnt), k);
            chk("run_busy", int'(busy), 1);
            chk("run_done", int'(done), 0);
            if (k == 0) begin
                len = ~v.len;
                req = 4'hF;
            end
            if (k == v.drop_at) req[v.id] = 1'b0;
        end
        @(negedge clk);
        chk("dn_grant", int'(grant), 0);
        chk("dn_busy", int'(busy), 1);
        chk("dn_pulse", int'(done), 1);
        req = '0;
        @(negedge clk);
        chk("idle_grant", int'(grant), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_cnt", int'(cnt), fin);
        chk("idle_done", int'(done), 0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b0;
        req = '0;
        len = '0;
        #3;
        chk("rst_grant", int'(grant), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_id", int'(done_id), 0);
        chk("rst_abort", int'(abort), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("quiet_grant", int'(grant), 0);
            chk("quiet_cnt", int'(cnt), 0);
            chk("quiet_busy", int'(busy), 0);
            chk("quiet_done", int'(done), 0);
        end

        vecs[0] = '{4'b0001, mklen(3, 0, 0, 0), 0, 3, -1};
        vecs[1] = '{4'b0100, mklen(1, 1, 0, 1), 2, 8, -1};
        vecs[2] = '{4'b0010, mklen(0, 5, 0, 0), 1, 5, 2};
        vecs[3] = '{4'b1000, mklen(0, 0, 0, 2), 3, 2, -1};
        vecs[4] = '{4'b0110, mklen(0, 1, 4, 0), 1, 1, -1};
        vecs[5] = '{4'b0011, mklen(6, 7, 0, 0), 0, 6, -1};
        vecs[6] = '{4'b0001, mklen(4, 0, 0, 0), 0, 4, 0};
        vecs[7] = '{4'b0101, mklen(5, 0, 3, 0), 2, 3, 2};
        vecs[8] = '{4'b1111, mklen(7, 7, 7, 7), 3, 7, -1};
        vecs[9] = '{4'b1010, mklen(0, 2, 0, 4), 1, 2, -1};
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        rst = 1'b0;
        #1;
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_cnt", int'(cnt), 0);
        chk("rst2_id", int'(done_id), 0);
        @(negedge clk);
        rst = 1'b1;

        len = mklen(1, 1, 1, 1);
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            e.id    = i % 4;
            e.abort = 1'b0;
            e.cnt   = 0;
            sb.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_grant", int'(grant), 1 << (i % 4));
            chk("rr_cnt", int'(cnt), 0);
            @(negedge clk);
            chk("rr_dn_grant", int'(grant), 0);
            chk("rr_dn_pulse", int'(done), 1);
            if (i == 4) req = '0;
            @(negedge clk);
            chk("rr_idle_grant", int'(grant), 0);
            chk("rr_idle_busy", int'(busy), 0);
        end

        req = 4'b0100;
        len = mklen(0, 0, 6, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("pre_grant", int'(grant), 4);
            chk("pre_cnt", int'(cnt), k);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("async_grant", int'(grant), 0);
        chk("async_cnt", int'(cnt), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        req = '0;
        @(negedge clk);
        chk("hold_grant", int'(grant), 0);
        chk("hold_cnt", int'(cnt), 0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_done", int'(done), 0);
            chk("post_busy", int'(busy), 0);
        end

        tail_v = '{4'b1001, mklen(2, 0, 0, 0), 0, 2, -1};
        run_vec(tail_v);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
